// File: rtl/qmax_update_pkg.sv
// Purpose: shared FP32 field layout and table geometry for the qmax update path.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package qmax_update_pkg;

  // IEEE-754 single precision field positions
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;

  localparam logic [EXP_MSB-EXP_LSB:0] EXP_ALL_ONES = '1;

  // Geometry shared with the qmax BRAM table
  localparam int QMAX_ADDR_WIDTH = 16;
  localparam int QMAX_DATA_WIDTH = 32;

  // Exponent all ones with a non-zero mantissa; infinities are not NaN
  function automatic logic fp32_is_nan(input logic [31:0] f);
    return (f[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (f[MAN_MSB:0] != '0);
  endfunction

  // Magnitude with the sign stripped; ordering of magnitudes matches unsigned order
  function automatic logic [EXP_MSB:0] fp32_mag(input logic [31:0] f);
    return f[EXP_MSB:0];
  endfunction

endpackage

// File: rtl/qmax_update_fp32_gt.sv
// Purpose: strict float32 a > b; any NaN operand yields false, +0 and -0 compare equal.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module fp32_gt
  import qmax_update_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b
);

  logic [EXP_MSB:0] a_mag;
  logic [EXP_MSB:0] b_mag;
  logic             any_nan;
  logic             both_zero;

  // Sign-magnitude ordering; negatives invert the magnitude comparison
  always_comb begin
    a_mag     = fp32_mag(a);
    b_mag     = fp32_mag(b);
    any_nan   = fp32_is_nan(a) | fp32_is_nan(b);
    both_zero = (a_mag == '0) && (b_mag == '0);
    a_gt_b    = 1'b0;
    if (!any_nan && !both_zero) begin
      unique case ({a[SIGN_BIT], b[SIGN_BIT]})
        2'b00:   a_gt_b = a_mag > b_mag;
        2'b01:   a_gt_b = 1'b1;
        2'b10:   a_gt_b = 1'b0;
        default: a_gt_b = a_mag < b_mag;
      endcase
    end
  end

endmodule

// File: rtl/qmax_update.sv
// Purpose: read-compare-write qmax table updater with same-state hazard forwarding; QMAX_UPD_STATS_EN adds accept/write counters.
// Latency: 2 cycles from accept to o_qmax_valid / o_wr_en, one update per cycle.
// Backpressure: none; o_ready is low only while i_rst is asserted.
module qmax_update
  import qmax_update_pkg::*;
#(
  parameter int ADDR_WIDTH = QMAX_ADDR_WIDTH,
  parameter int DATA_WIDTH = QMAX_DATA_WIDTH   // float32 only
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_state,
  input  logic [DATA_WIDTH-1:0] i_q,
  output logic                  o_ready,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_qmax_valid,
  output logic [DATA_WIDTH-1:0] o_qmax,
  output logic                  o_busy
`ifdef QMAX_UPD_STATS_EN
  ,
  output logic [31:0]           o_acc_cnt,
  output logic [31:0]           o_wr_cnt
`endif
);

  logic                  accept;

  // P2 (compare stage) registers
  logic                  p2_vld;
  logic [ADDR_WIDTH-1:0] p2_addr;
  logic [DATA_WIDTH-1:0] p2_q;

  // Write committed by the table in the previous cycle; the table returns
  // old data when a read collides with a same-cycle write, so this covers it
  logic                  hist_vld;
  logic [ADDR_WIDTH-1:0] hist_addr;
  logic [DATA_WIDTH-1:0] hist_dat;

  logic [DATA_WIDTH-1:0] cur;
  logic                  new_gt;

  // Accept handshake and read issue; no backpressure outside reset
  always_comb begin
    o_ready   = ~i_rst;
    accept    = i_valid & o_ready;
    o_rd_en   = accept;
    o_rd_addr = i_state;
    o_busy    = p2_vld | o_qmax_valid;
  end

  // Current stored value: newest in-flight write wins over the table read
  always_comb begin
    cur = i_rd_data;
    if (o_qmax_valid && o_wr_en && (o_wr_addr == p2_addr)) begin
      cur = o_wr_data;
    end else if (hist_vld && (hist_addr == p2_addr)) begin
      cur = hist_dat;
    end
  end

  fp32_gt u_gt (
    .a      (p2_q),
    .b      (cur),
    .a_gt_b (new_gt)
  );

  // P2 capture of accepted updates
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      p2_vld  <= 1'b0;
      p2_addr <= '0;
      p2_q    <= '0;
    end else begin
      p2_vld <= accept;
      if (accept) begin
        p2_addr <= i_state;
        p2_q    <= i_q;
      end
    end
  end

  // P3 registered write/result; address and qmax hold between results
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_qmax_valid <= 1'b0;
      o_qmax       <= '0;
    end else begin
      o_qmax_valid <= p2_vld;
      o_wr_en      <= p2_vld & new_gt;
      if (p2_vld) begin
        o_wr_addr <= p2_addr;
        o_qmax    <= new_gt ? p2_q : cur;
        if (new_gt) begin
          o_wr_data <= p2_q;
        end
      end
    end
  end

  // History of the write the table commits at this edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hist_vld  <= 1'b0;
      hist_addr <= '0;
      hist_dat  <= '0;
    end else begin
      hist_vld  <= o_wr_en;
      hist_addr <= o_wr_addr;
      hist_dat  <= o_wr_data;
    end
  end

`ifdef QMAX_UPD_STATS_EN
  // Free-running accept/write counters, wrapping at 2^32
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_acc_cnt <= '0;
      o_wr_cnt  <= '0;
    end else begin
      if (accept) o_acc_cnt <= o_acc_cnt + 32'd1;
      if (o_wr_en) o_wr_cnt <= o_wr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qmax_update.sv
// Purpose: self-checking bench for qmax_update with a behavioural qmax table and expected-result queue.
// Latency: results expected exactly 2 cycles after each accept.
// Backpressure: none expected; o_ready checked around reset.
module tb_qmax_update;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic [AW-1:0] i_state;
  logic [DW-1:0] i_q;
  logic          o_ready;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic [DW-1:0] i_rd_data;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic          o_qmax_valid;
  logic [DW-1:0] o_qmax;
  logic          o_busy;
`ifdef QMAX_UPD_STATS_EN
  logic [31:0]   o_acc_cnt;
  logic [31:0]   o_wr_cnt;
`endif

  always #5 i_clk = ~i_clk;

  qmax_update #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_state      (i_state),
    .i_q          (i_q),
    .o_ready      (o_ready),
    .o_rd_en      (o_rd_en),
    .o_rd_addr    (o_rd_addr),
    .i_rd_data    (i_rd_data),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_qmax_valid (o_qmax_valid),
    .o_qmax       (o_qmax),
    .o_busy       (o_busy)
`ifdef QMAX_UPD_STATS_EN
    ,
    .o_acc_cnt    (o_acc_cnt),
    .o_wr_cnt     (o_wr_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural qmax table: 1-cycle read, read-old-data on collision
  bit [31:0]     mem [0:65535];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_dat = '0;

  always @(posedge i_clk) begin
    if (o_rd_en) i_rd_data <= mem[o_rd_addr];
    if (pre_en) mem[pre_addr] <= pre_dat;
    else if (o_wr_en) mem[o_wr_addr] <= o_wr_data;
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] qmax;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic mon_en = 1'b0;
  int   n_acc = 0;
  int   n_wr = 0;

  // Result monitor, sampling away from the active edge
  always @(negedge i_clk) begin
    if (mon_en && o_qmax_valid) begin
      check("result_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("latency", 32'(cyc), 32'(mon_e.cyc));
        check("wr_addr", 32'(o_wr_addr), 32'(mon_e.addr));
        check("wr_en", 32'(o_wr_en), 32'(mon_e.wr));
        check("qmax", o_qmax, mon_e.qmax);
        if (mon_e.wr) check("wr_data", o_wr_data, mon_e.qmax);
      end
    end
  end

  // float32 bits -> real (normals, zeros, inf, NaN) for an independent ordering model
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    logic [63:0] d;
    if (f[30:23] == 8'h00) e = 11'h000;
    else if (f[30:23] == 8'hFF) e = 11'h7FF;
    else e = 11'(f[30:23]) + 11'd896;
    d = {f[31], e, f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic ref_gt(input logic [31:0] a, input logic [31:0] b);
    return f2r(a) > f2r(b);
  endfunction

  function automatic logic [31:0] rand_q();
    int r;
    logic [31:0] v;
    r = $urandom_range(0, 15);
    case (r)
      0:       v = 32'h0000_0000;
      1:       v = 32'h8000_0000;
      2:       v = 32'h7FC0_0000;
      3:       v = 32'hFF80_0000;
      default: v = {1'($urandom_range(0, 3) == 0), 8'($urandom_range(124, 131)),
                    3'($urandom_range(0, 7)), 20'h0};
    endcase
    return v;
  endfunction

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_dat = d;
    @(posedge i_clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic upd(input logic [AW-1:0] s, input logic [DW-1:0] q,
                     input logic ew, input logic [DW-1:0] eq);
    exp_t e;
    e.cyc = cyc + 2; e.addr = s; e.wr = ew; e.qmax = eq;
    exp_q.push_back(e);
    n_acc++;
    if (ew) n_wr++;
    i_valid = 1'b1; i_state = s; i_q = q;
    #1;
    check("rd_en", 32'(o_rd_en), 32'd1);
    check("rd_addr", 32'(o_rd_addr), 32'(s));
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || o_busy) && k < 10) begin
      @(posedge i_clk); #1;
      k++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    check("drain_busy", 32'(o_busy), 32'd0);
  endtask

  logic [31:0] ref_max [0:7];

  initial begin
    logic [AW-1:0] s;
    logic [DW-1:0] q;
    logic          ew;
    logic [DW-1:0] eq;
    int            k;

    i_rst = 1'b1; i_valid = 1'b0; i_state = '0; i_q = '0;
    @(posedge i_clk); #1;
    // preload: one negative entry for directed tests, four for the random stream
    poke(16'd12, 32'hC000_0000);
    for (int j = 0; j < 8; j++) begin
      ref_max[j] = (j < 4) ? 32'hC2C8_0000 : 32'h0;
      poke(16'(16 + j), ref_max[j]);
    end

    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_wr_en", 32'(o_wr_en), 32'd0);
    check("rst_qmax_valid", 32'(o_qmax_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_qmax", o_qmax, 32'd0);
    check("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    check("rst_wr_data", o_wr_data, 32'd0);
`ifdef QMAX_UPD_STATS_EN
    check("rst_acc_cnt", o_acc_cnt, 32'd0);
    check("rst_wr_cnt", o_wr_cnt, 32'd0);
`endif

    i_rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(o_ready), 32'd1);
    mon_en = 1'b1;

    // 1: first write on a zero table
    upd(16'd5, 32'h3F80_0000, 1'b1, 32'h3F80_0000);
    drain();

    // 2: back-to-back same state, P3 forwarding
    upd(16'd7, 32'h4000_0000, 1'b1, 32'h4000_0000);
    upd(16'd7, 32'h3FC0_0000, 1'b0, 32'h4000_0000);
    drain();
    check("mem7", mem[7], 32'h4000_0000);

    // 3: one-cycle gaps, history forwarding; 2.8 must not overwrite 3.0
    upd(16'd9, 32'h3F80_0000, 1'b1, 32'h3F80_0000);
    idle(1);
    upd(16'd9, 32'h4020_0000, 1'b1, 32'h4020_0000);
    idle(1);
    upd(16'd9, 32'h4040_0000, 1'b1, 32'h4040_0000);
    idle(1);
    upd(16'd9, 32'h4033_3333, 1'b0, 32'h4040_0000);
    drain();
    check("mem9", mem[9], 32'h4040_0000);

    // 4: negatives and -0 never beat a zero entry
    upd(16'd3, 32'hBF80_0000, 1'b0, 32'h0000_0000);
    upd(16'd3, 32'h8000_0000, 1'b0, 32'h0000_0000);
    drain();
    check("mem3", mem[3], 32'h0000_0000);

    // 5: NaN is never written, reports stored value (forwarded and via history)
    upd(16'd4, 32'h4000_0000, 1'b1, 32'h4000_0000);
    upd(16'd4, 32'h7FC0_0000, 1'b0, 32'h4000_0000);
    idle(1);
    upd(16'd4, 32'h7FC0_0000, 1'b0, 32'h4000_0000);
    drain();
    check("mem4", mem[4], 32'h4000_0000);

    // both negative: smaller magnitude wins
    upd(16'd12, 32'hBF80_0000, 1'b1, 32'hBF80_0000);
    upd(16'd12, 32'hC040_0000, 1'b0, 32'hBF80_0000);
    drain();
    check("mem12", mem[12], 32'hBF80_0000);

    // continuous random stream over 8 states
    for (int i = 0; i < 1000; i++) begin
      k  = $urandom_range(0, 7);
      s  = 16'(16 + k);
      q  = rand_q();
      ew = ref_gt(q, ref_max[k]);
      eq = ew ? q : ref_max[k];
      if (ew) ref_max[k] = q;
      upd(s, q, ew, eq);
    end
    drain();
    for (int j = 0; j < 8; j++) check("rand_table", mem[16 + j], ref_max[j]);
`ifdef QMAX_UPD_STATS_EN
    check("acc_cnt", o_acc_cnt, 32'(n_acc));
    check("wr_cnt", o_wr_cnt, 32'(n_wr));
`endif

    // 6: reset with two updates in flight; state 31 must never be written
    upd(16'd30, 32'h3F80_0000, 1'b1, 32'h3F80_0000);
    i_valid = 1'b1; i_state = 16'd31; i_q = 32'h3F80_0000;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    exp_q.delete();
    check("rst_flight_wr_en", 32'(o_wr_en), 32'd0);
    check("rst_flight_busy", 32'(o_busy), 32'd0);
    check("rst_flight_qvld", 32'(o_qmax_valid), 32'd0);
    check("rst_flight_ready", 32'(o_ready), 32'd0);
`ifdef QMAX_UPD_STATS_EN
    check("rst_flight_acc", o_acc_cnt, 32'd0);
    check("rst_flight_wr", o_wr_cnt, 32'd0);
`endif
    @(posedge i_clk); #1;
    check("rst_hold_wr_en", 32'(o_wr_en), 32'd0);
    i_rst = 1'b0;
    idle(3);
    check("post_rst_wr_en", 32'(o_wr_en), 32'd0);
    check("mem31", mem[31], 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/qmax_update.md
Name: qmax_update

Overview:
- Streaming read-compare-write stage directly upstream of the qmax BRAM table.
- Accepts (state, candidate Q) updates, reads the stored qmax, and compares in IEEE-754 single precision.
- Writes back only when the candidate is strictly greater, and reports the resulting qmax downstream.
- Fully pipelined at one update per cycle, with address-hazard forwarding so back-to-back updates to the same state are exact.

Parameters:
ADDR_WIDTH, 16, state index width; must match the qmax table.
DATA_WIDTH, 32, Q value width; fixed IEEE-754 single, other values unsupported.

Ports:
i_clk  in  1  clock.
i_rst  in  1  synchronous active-high reset.
i_valid  in  1  update request valid.
i_state  in  ADDR_WIDTH  state index of the update.
i_q  in  DATA_WIDTH  candidate Q value (float32).
o_ready  out  1  accept; update taken when i_valid&o_ready.
o_rd_en  out  1  table read enable (combinational, = i_valid&o_ready).
o_rd_addr  out  ADDR_WIDTH  table read address (= i_state).
i_rd_data  in  DATA_WIDTH  table read data, valid one cycle after o_rd_en.
o_wr_en  out  1  table write enable (registered).
o_wr_addr  out  ADDR_WIDTH  table write address.
o_wr_data  out  DATA_WIDTH  table write data.
o_qmax_valid  out  1  result strobe.
o_qmax  out  DATA_WIDTH  qmax of the state after this update.
o_busy  out  1  any update in flight.

Behaviour:
- Reset: all output registers and pipeline valids are 0; o_ready = 0 while i_rst = 1, otherwise 1 (no backpressure).
- A reset mid-operation drops all in-flight updates; no write is issued for them.
- Pipeline for an update accepted at cycle t:
  - P1, cycle t: read is issued.
  - P2, cycle t+1: compare stage; i_rd_data is sampled.
  - P3, cycle t+2: o_wr_en, o_qmax_valid and registers are driven; the table commits at the end of t+2.
  - Fixed latency is 2 cycles.
- Current value in P2 uses this priority:
  1. P3 register, if P3 valid, its wr_en = 1, and its address equals the P2 address.
  2. Else the history register (the write committed in the previous cycle), if valid and the address matches.
  3. Else i_rd_data.
  - This covers the read-old-data-on-collision behaviour of the table.
- Compare: new > cur, strictly, in float order.
  - Sign-magnitude compare; +0 and -0 are treated as equal.
  - If both are negative, the larger magnitude is smaller.
- P3 outputs:
  - If greater: wr_en = 1, o_wr_data = i_q, o_qmax = i_q.
  - Else: wr_en = 0, o_qmax = cur.
  - o_qmax_valid = 1 for every accepted update; o_wr_addr and o_qmax are held when not valid.
- NaN input (exp = all ones, mantissa ≠ 0): never written, o_qmax = cur.
- History register: captures {addr, data, valid = o_wr_en} each cycle; cleared on reset.
- o_busy = P2 valid | P3 valid.
- Table initial contents are assumed zero-filled by the table. A negative first update leaves qmax = 0.

Optional Feature:
QMAX_UPD_STATS_EN:
- When defined, adds outputs o_acc_cnt[31:0] (accepted updates) and o_wr_cnt[31:0] (writes issued).
- Both reset to 0, increment on accept and on o_wr_en respectively, and wrap at 2^32.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - FP32 field constants: SIGN_BIT = 31, EXP_MSB = 30, EXP_LSB = 23, MAN_MSB = 22.
  - EXP_ALL_ONES.
  - Default ADDR_WIDTH/DATA_WIDTH shared with the qmax table.
- One sub-module, fp32_gt: combinational strict-greater compare with NaN and signed-zero rules, reusable by the action-select max stage.

Test Plan:
1. Reset, then update (5, 0x3F800000 = 1.0) → at t+2: o_wr_en = 1, addr 5, data 0x3F800000, o_qmax = 1.0.
2. Back-to-back (7, 2.0) then (7, 1.5) → second result o_qmax = 2.0 with o_wr_en = 0 (P3 forwarding).
3. (9, 1.0), idle, (9, 3.0) preceded by (9, 2.5) one cycle gap → final table value 3.0 (history forwarding); the 2.5 update writes, and no stale-read overwrite occurs.
4. (3, 0xBF800000 = −1.0) on a zero table → no write, o_qmax = 0; then (3, 0x80000000 = −0.0) → no write.
5. (4, 0x7FC00000 NaN) → no write, o_qmax = stored value; continuous 1000 random updates checked against a reference max model with zero mismatches.
6. Assert i_rst with two updates in flight → no o_wr_en afterward, o_busy = 0 next cycle; with QMAX_UPD_STATS_EN, counters read 0.
